// File: rtl/lcd_access_arbiter.sv
// Round-robin arbiter sharing a 4-bit HD44780 nibble interface between byte requesters.
// Each granted byte is sent high nibble first, then the LCD settle time is enforced.
module lcd_access_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned SHORT_WAIT_CYC = 1080,
  parameter int unsigned LONG_WAIT_CYC  = 41040
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ-1:0]   i_req_lock,
  input  logic [NUM_REQ-1:0]   i_req_rs,
  input  logic [NUM_REQ*8-1:0] i_req_data,
  input  logic                 i_is_ready,
  output logic [NUM_REQ-1:0]   o_req_ack,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [3:0]           o_display_data,
  output logic                 o_display_data_valid,
  output logic                 o_RS,
  output logic                 o_busy
);

  localparam int unsigned OwnW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (LONG_WAIT_CYC > 1) ? $clog2(LONG_WAIT_CYC) : 1;
  localparam logic [CntW-1:0] LongLoad  = CntW'(LONG_WAIT_CYC - 1);
  localparam logic [CntW-1:0] ShortLoad = CntW'(SHORT_WAIT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StHiNib, StLoNib, StWait, StHold} state_e;

  state_e              state_q, state_d;
  logic [OwnW-1:0]     owner_q, owner_d;
  logic [OwnW-1:0]     last_q, last_d;
  logic [7:0]          byte_q, byte_d;
  logic                rs_q, rs_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;

  logic [OwnW-1:0]     rr_sel;
  logic [OwnW-1:0]     rr_cand;

  // Scan downward so the requester closest after last_q is the last to be assigned.
  always_comb begin
    rr_sel  = last_q;
    rr_cand = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      rr_cand = OwnW'((int'(last_q) + i) % NUM_REQ);
      if (i_req[rr_cand]) begin
        rr_sel = rr_cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    byte_d  = byte_q;
    rs_d    = rs_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (|i_req) begin
          owner_d        = rr_sel;
          byte_d         = i_req_data[{rr_sel, 3'b000} +: 8];
          rs_d           = i_req_rs[rr_sel];
          ack_d[rr_sel]  = 1'b1;
          state_d        = StHiNib;
        end
      end
      StHiNib: begin
        if (i_is_ready) state_d = StLoNib;
      end
      StLoNib: begin
        if (i_is_ready) begin
          state_d = StWait;
          // Clear display and return home need the long settle time.
          cnt_d   = (!rs_q && (byte_q[7:2] == 6'd0)) ? LongLoad : ShortLoad;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          if (i_req_lock[owner_q]) begin
            state_d = StHold;
          end else begin
            state_d = StIdle;
            last_d  = owner_q;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (i_req[owner_q]) begin
          byte_d          = i_req_data[{owner_q, 3'b000} +: 8];
          rs_d            = i_req_rs[owner_q];
          ack_d[owner_q]  = 1'b1;
          state_d         = StHiNib;
        end else if (!i_req_lock[owner_q]) begin
          state_d = StIdle;
          last_d  = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= OwnW'(NUM_REQ - 1);
      byte_q  <= '0;
      rs_q    <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      byte_q  <= byte_d;
      rs_q    <= rs_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    o_req_ack            = ack_q;
    o_grant              = '0;
    o_display_data       = 4'h0;
    o_display_data_valid = 1'b0;
    o_RS                 = 1'b0;
    o_busy               = (state_q != StIdle);
    if (state_q != StIdle) begin
      o_grant[owner_q] = 1'b1;
    end
    if (state_q == StHiNib) begin
      o_display_data_valid = 1'b1;
      o_display_data       = byte_q[7:4];
      o_RS                 = rs_q;
    end else if (state_q == StLoNib) begin
      o_display_data_valid = 1'b1;
      o_display_data       = byte_q[3:0];
      o_RS                 = rs_q;
    end
  end

endmodule

// File: tb/tb_lcd_access_arbiter.sv
// Randomized scoreboard bench for lcd_access_arbiter: drivers push expected bytes per requester,
// a negedge monitor predicts the round-robin owner, nibble order and settle length.
module tb_lcd_access_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned SW = 10;
  localparam int unsigned LW = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic       req_b [NR];
  logic       lock_b[NR];
  logic       rs_b  [NR];
  logic [7:0] data_b[NR];

  logic [NR-1:0]   i_req, i_lock, i_rs;
  logic [NR*8-1:0] i_data;
  logic            ready = 1'b0;

  logic [NR-1:0] o_req_ack, o_grant;
  logic [3:0]    o_dd;
  logic          o_dv, o_rs, o_busy;

  always_comb begin
    i_req  = '0;
    i_lock = '0;
    i_rs   = '0;
    i_data = '0;
    for (int k = 0; k < NR; k++) begin
      i_req[k]         = req_b[k];
      i_lock[k]        = lock_b[k];
      i_rs[k]          = rs_b[k];
      i_data[8*k +: 8] = data_b[k];
    end
  end

  lcd_access_arbiter #(
    .NUM_REQ       (NR),
    .SHORT_WAIT_CYC(SW),
    .LONG_WAIT_CYC (LW)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_req               (i_req),
    .i_req_lock          (i_lock),
    .i_req_rs            (i_rs),
    .i_req_data          (i_data),
    .i_is_ready          (ready),
    .o_req_ack           (o_req_ack),
    .o_grant             (o_grant),
    .o_display_data      (o_dd),
    .o_display_data_valid(o_dv),
    .o_RS                (o_rs),
    .o_busy              (o_busy)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // 0 = random, 1 = forced low, 2 = forced high
  int ready_mode = 1;
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       ready = ($urandom_range(0, 3) != 0);
      2:       ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Reference model state
  logic [8:0]    exp_q[NR][$];
  bit            mon_en = 0;
  int            phase = 0;  // 0 idle, 1 high nibble, 2 low nibble, 3 settle
  int            owner_m = 0;
  int            last_m = NR - 1;
  logic [7:0]    cur_b;
  logic          cur_rs;
  bit            gap_chk;
  int            gap;
  logic [NR-1:0] prev_req = '0;
  logic          prev_busy = 1'b0;

  function automatic int rr_pick(input logic [NR-1:0] r, input int last);
    for (int i = 1; i <= NR; i++) begin
      if (r[(last + i) % NR]) return (last + i) % NR;
    end
    return -1;
  endfunction

  function automatic int settle_len(input logic [7:0] b, input logic rs);
    // clear / home commands are the slow ones
    return (!rs && b < 8'h04) ? LW : SW;
  endfunction

  always @(negedge clk) begin
    int            exp_o, got_o;
    logic [8:0]    e;
    logic [NR-1:0] oh;
    if (mon_en && rst_n) begin
      if (o_req_ack != '0) begin
        got_o = -1;
        for (int i = 0; i < NR; i++) if (o_req_ack[i]) got_o = i;
        exp_o = prev_busy ? owner_m : rr_pick(prev_req, last_m);
        check("ack_onehot", 32'($onehot(o_req_ack)), 32'd1);
        check("ack_owner", 32'(got_o), 32'(exp_o));
        check("ack_phase", 32'(phase == 0 || phase == 3), 32'd1);
        if (got_o >= 0 && exp_q[got_o].size() > 0) begin
          e = exp_q[got_o].pop_front();
          cur_b = e[7:0];
          cur_rs = e[8];
        end else begin
          check("ack_unexpected", 32'd1, 32'd0);
        end
        owner_m = (got_o >= 0) ? got_o : 0;
        gap_chk = !lock_b[owner_m];
        phase = 1;
      end
      oh = NR'(1) << owner_m;
      case (phase)
        1: begin
          check("hi_nibble", 32'({o_dv, o_dd, o_rs, o_grant}), 32'({1'b1, cur_b[7:4], cur_rs, oh}));
          if (ready) phase = 2;
        end
        2: begin
          check("lo_nibble", 32'({o_dv, o_dd, o_rs, o_grant}), 32'({1'b1, cur_b[3:0], cur_rs, oh}));
          if (ready) begin
            phase = 3;
            gap = 0;
          end
        end
        3: begin
          if (!o_busy) begin
            if (gap_chk) check("settle_len", 32'(gap), 32'(settle_len(cur_b, cur_rs)));
            check("release_out", 32'({o_grant, o_dv}), 32'd0);
            last_m = owner_m;
            phase = 0;
          end else begin
            check("settle_out", 32'({o_dv, o_dd, o_rs, o_grant}), 32'(oh));
            gap++;
          end
        end
        default: check("idle_out", 32'({o_busy, o_dv, o_grant}), 32'd0);
      endcase
    end
    prev_req  = i_req;
    prev_busy = o_busy;
  end

  task automatic send_one(input int k, input logic [7:0] d, input logic r);
    int n;
    @(posedge clk);
    #1;
    data_b[k] = d;
    rs_b[k]   = r;
    req_b[k]  = 1'b1;
    exp_q[k].push_back({r, d});
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!o_req_ack[k] && n < 3000);
    if (n >= 3000) check("ack_timeout", 32'(k), 32'hFFFF);
  endtask

  task automatic send_rand(input int k, input int cnt, input int gapmax);
    logic [7:0] d;
    logic       r;
    int         g;
    for (int i = 0; i < cnt; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        d = 8'($urandom_range(0, 3));
        r = 1'b0;
      end else begin
        d = 8'($urandom);
        r = 1'($urandom);
      end
      send_one(k, d, r);
      g = $urandom_range(0, gapmax);
      if (g > 0 || i == cnt - 1) req_b[k] = 1'b0;
      repeat (g) @(posedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((o_busy || i_req != '0) && n < 3000);
    if (n >= 3000) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    bit done1;
    for (int k = 0; k < NR; k++) begin
      req_b[k] = 1'b0; lock_b[k] = 1'b0; rs_b[k] = 1'b0; data_b[k] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check("reset_out", 32'({o_req_ack, o_grant, o_dv, o_dd, o_rs, o_busy}), 32'd0);
    rst_n = 1'b1;
    mon_en = 1;
    @(negedge clk);
    check("post_reset_out", 32'({o_req_ack, o_grant, o_dv, o_dd, o_rs, o_busy}), 32'd0);

    // Directed bytes with the engine always ready
    ready_mode = 2;
    send_one(0, 8'h41, 1'b1); req_b[0] = 1'b0; wait_idle();
    send_one(1, 8'h01, 1'b0); req_b[1] = 1'b0; wait_idle();
    send_one(1, 8'h80, 1'b0); req_b[1] = 1'b0; wait_idle();

    // Both requesting back-to-back: alternation
    fork
      send_rand(0, 4, 0);
      send_rand(1, 4, 0);
    join
    wait_idle();

    // Random traffic with random engine readiness
    ready_mode = 0;
    fork
      send_rand(0, 12, 4);
      send_rand(1, 12, 4);
    join
    wait_idle();

    // Engine stalls in the high nibble
    ready_mode = 1;
    send_one(0, 8'hC3, 1'b1);
    req_b[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("stall_hold", 32'({o_dv, o_dd}), 32'({1'b1, 4'hC}));
    ready_mode = 0;
    wait_idle();

    // Locked multi-byte transaction with a competing requester
    ready_mode = 2;
    lock_b[0] = 1'b1;
    send_one(0, 8'h80, 1'b0);
    done1 = 0;
    fork
      begin
        send_one(1, 8'h55, 1'b1);
        done1 = 1;
      end
    join_none
    send_one(0, 8'h31, 1'b1);
    send_one(0, 8'h32, 1'b1);
    req_b[0] = 1'b0;
    repeat (30) @(negedge clk);
    check("lock_grant", 32'(o_grant), 32'd1);
    @(posedge clk);
    #1;
    lock_b[0] = 1'b0;
    n = 0;
    while (!done1 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (!done1) check("lock_release_timeout", 32'd0, 32'd1);
    #1;
    req_b[1] = 1'b0;
    wait_idle();

    // Reset in the middle of the low nibble
    mon_en = 0;
    ready_mode = 1;
    @(posedge clk);
    #1;
    data_b[0] = 8'h5A; rs_b[0] = 1'b1; req_b[0] = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!o_req_ack[0] && n < 100);
    if (n >= 100) check("rst_ack_timeout", 32'd0, 32'd1);
    req_b[0] = 1'b0;
    ready_mode = 2;
    @(posedge clk);
    #1;
    ready_mode = 1;
    @(negedge clk);
    check("lo_before_rst", 32'({o_dv, o_dd, o_rs}), 32'({1'b1, 4'hA, 1'b1}));
    rst_n = 1'b0;
    #1;
    check("rst_async", 32'({o_req_ack, o_grant, o_dv, o_dd, o_rs, o_busy}), 32'd0);
    @(negedge clk);
    check("rst_hold", 32'({o_req_ack, o_grant, o_dv, o_dd, o_rs, o_busy}), 32'd0);
    #1;
    rst_n = 1'b1;
    last_m = NR - 1;
    phase = 0;
    for (int k = 0; k < NR; k++) exp_q[k].delete();
    mon_en = 1;
    ready_mode = 0;
    fork
      send_rand(0, 2, 0);
      send_rand(1, 2, 0);
    join
    wait_idle();

    for (int k = 0; k < NR; k++) check("queue_drained", 32'(exp_q[k].size()), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
